// File: rtl/mfi_check_pkg.sv
// Shared types for the MFI formal-check family: checker FSM states and the default order type.
package mfi_check_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DONE    = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam int ORDER_W_DFLT = 32;

  typedef logic [ORDER_W_DFLT-1:0] order_t;

endpackage

// File: rtl/mfi_liveness_window_check_if.sv
// MFI retirement trace bundle: per-channel valid, order and halt.
interface mfi_liveness_window_check_if #(
  parameter int NRET    = 1,
  parameter int ORDER_W = 32
);

  logic [NRET-1:0]         mfi_valid;
  logic [NRET*ORDER_W-1:0] mfi_order;
  logic [NRET-1:0]         mfi_halt;

  modport master (output mfi_valid, output mfi_order, output mfi_halt);
  modport slave  (input  mfi_valid, input  mfi_order, input  mfi_halt);

endinterface

// File: rtl/mfi_order_window_match.sv
// Compares every retiring channel against the DEPTH successor orders of inst_order.
module mfi_order_window_match #(
  parameter int NRET    = 1,
  parameter int DEPTH   = 1,
  parameter int ORDER_W = 32
) (
  input  logic [NRET-1:0]         valid_i,
  input  logic [NRET*ORDER_W-1:0] order_i,
  input  logic [NRET-1:0]         halt_i,
  input  logic [ORDER_W-1:0]      inst_order_i,
  output logic [DEPTH-1:0]        hit_o,
  output logic [DEPTH-1:0]        halt_hit_o
);

  logic [ORDER_W-1:0] target;

  // Targets wrap modulo 2^ORDER_W; a halt on the last target cannot shorten the window.
  always_comb begin
    hit_o      = '0;
    halt_hit_o = '0;
    target     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      target = inst_order_i + ORDER_W'(k + 1);
      for (int c = 0; c < NRET; c++) begin
        if (valid_i[c] && (order_i[c*ORDER_W +: ORDER_W] == target)) begin
          hit_o[k] = 1'b1;
          if (halt_i[c] && (k < DEPTH - 1)) halt_hit_o[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mfi_liveness_window_check.sv
// Liveness checker: after trig, the next DEPTH orders (or up to a halt) must retire,
// optionally within MAX_WAIT cycles. inst_order_i must be held constant by the harness.
module mfi_liveness_window_check
  import mfi_check_pkg::*;
#(
  parameter  int NRET      = 1,
  parameter  int DEPTH     = 1,
  parameter  int ORDER_W   = 32,
  parameter  int MAX_WAIT  = 0,
  parameter  int ASSERT_EN = 1,
  localparam int CNT_W     = $clog2(MAX_WAIT + 2)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ORDER_W-1:0]   inst_order_i,
  input  logic                 trig_i,
  input  logic                 check_i,
  mfi_liveness_window_check_if.slave mfi_if,
  output logic                 armed_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     wait_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_WAIT + 1);

  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] halt_hit;
  logic [DEPTH-1:0] found_q, found_d;
  logic [DEPTH-1:0] cut_q, cut_d;
  logic [DEPTH-1:0] required;
  logic             cut_seen;
  logic             complete;
  logic             deadline_hit;

  state_e           state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             armed_q;
  logic             done_q;

  mfi_order_window_match #(
    .NRET    (NRET),
    .DEPTH   (DEPTH),
    .ORDER_W (ORDER_W)
  ) u_match (
    .valid_i      (mfi_if.mfi_valid),
    .order_i      (mfi_if.mfi_order),
    .halt_i       (mfi_if.mfi_halt),
    .inst_order_i (inst_order_i),
    .hit_o        (hit),
    .halt_hit_o   (halt_hit)
  );

  assign found_d = found_q | hit;
  assign cut_d   = cut_q | halt_hit;

  // A target is required only while no halt has been seen on an earlier target,
  // so the smallest halting order defines the window.
  always_comb begin
    required = '0;
    cut_seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      required[i] = ~cut_seen;
      cut_seen    = cut_seen | cut_q[i];
    end
  end

  assign complete     = ((found_q & required) == required);
  assign deadline_hit = (MAX_WAIT > 0) && (wait_cnt_q == CNT_W'(MAX_WAIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      found_q <= '0;
      cut_q   <= '0;
    end else begin
      found_q <= found_d;
      cut_q   <= cut_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_i) begin
            state_q    <= WAIT;
            wait_cnt_q <= CNT_W'(1);
            armed_q    <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt_q != CNT_SAT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          if (complete) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (deadline_hit) begin
            state_q <= EXPIRED;
          end
        end
        default: ;
      endcase
    end
  end

  assign armed_o    = armed_q;
  assign done_o     = done_q;
  assign wait_cnt_o = wait_cnt_q;

  generate
    if (ASSERT_EN != 0) begin : g_assert
      always @(posedge clock) begin
        if (!reset && check_i) assert (state_q == DONE || state_q == IDLE);
        if (!reset) assert (state_q != EXPIRED);
      end
    end
  endgenerate

endmodule

// File: tb/tb_mfi_liveness_window_check.sv
// Directed bench for mfi_liveness_window_check across four parameterisations,
// checked through a cycle-stamped expectation queue.
module tb_mfi_liveness_window_check;

  localparam int F_ARMED = 0;
  localparam int F_DONE  = 1;
  localparam int F_WC    = 2;
  localparam int F_FOUND = 3;

  typedef struct {
    int          cyc;
    int          dut;
    int          fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] inst  [1:4];
  logic        trig  [1:4];
  logic        check [1:4];
  logic        armed [1:4];
  logic        done  [1:4];
  logic [0:0]  wc1, wc2;
  logic [3:0]  wc3;
  logic [2:0]  wc4;

  mfi_liveness_window_check_if #(.NRET(1), .ORDER_W(32)) mi1 ();
  mfi_liveness_window_check_if #(.NRET(2), .ORDER_W(32)) mi2 ();
  mfi_liveness_window_check_if #(.NRET(2), .ORDER_W(32)) mi3 ();
  mfi_liveness_window_check_if #(.NRET(2), .ORDER_W(32)) mi4 ();

  mfi_liveness_window_check #(.NRET(1), .DEPTH(1), .ORDER_W(32), .MAX_WAIT(0), .ASSERT_EN(1)) u1 (
    .clock(clock), .reset(reset), .inst_order_i(inst[1]), .trig_i(trig[1]), .check_i(check[1]),
    .mfi_if(mi1), .armed_o(armed[1]), .done_o(done[1]), .wait_cnt_o(wc1));
  mfi_liveness_window_check #(.NRET(2), .DEPTH(3), .ORDER_W(32), .MAX_WAIT(0), .ASSERT_EN(1)) u2 (
    .clock(clock), .reset(reset), .inst_order_i(inst[2]), .trig_i(trig[2]), .check_i(check[2]),
    .mfi_if(mi2), .armed_o(armed[2]), .done_o(done[2]), .wait_cnt_o(wc2));
  mfi_liveness_window_check #(.NRET(2), .DEPTH(4), .ORDER_W(32), .MAX_WAIT(8), .ASSERT_EN(1)) u3 (
    .clock(clock), .reset(reset), .inst_order_i(inst[3]), .trig_i(trig[3]), .check_i(check[3]),
    .mfi_if(mi3), .armed_o(armed[3]), .done_o(done[3]), .wait_cnt_o(wc3));
  // Deadline instance: it is driven into EXPIRED on purpose, so its assertions are off.
  mfi_liveness_window_check #(.NRET(2), .DEPTH(2), .ORDER_W(32), .MAX_WAIT(4), .ASSERT_EN(0)) u4 (
    .clock(clock), .reset(reset), .inst_order_i(inst[4]), .trig_i(trig[4]), .check_i(check[4]),
    .mfi_if(mi4), .armed_o(armed[4]), .done_o(done[4]), .wait_cnt_o(wc4));

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int dut, input int fld);
    logic [31:0] r;
    r = '0;
    case (fld)
      F_ARMED: r = 32'(armed[dut]);
      F_DONE:  r = 32'(done[dut]);
      F_WC: begin
        case (dut)
          1: r = 32'(wc1);
          2: r = 32'(wc2);
          3: r = 32'(wc3);
          default: r = 32'(wc4);
        endcase
      end
      default: begin
        case (dut)
          1: r = 32'(u1.found_q);
          2: r = 32'(u2.found_q);
          3: r = 32'(u3.found_q);
          default: r = 32'(u4.found_q);
        endcase
      end
    endcase
    return r;
  endfunction

  // Monitor: compares every expectation stamped for the current cycle.
  always @(negedge clock) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        logic [31:0] a;
        a = actual(sbq[i].dut, sbq[i].fld);
        n_cmp++;
        if (sbq[i].cyc < cyc) begin
          n_bad++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", sbq[i].name, sbq[i].cyc, cyc);
        end else if (a !== sbq[i].val) begin
          n_bad++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", sbq[i].name, a, sbq[i].val, cyc);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_now(input int dut, input int fld, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.dut  = dut;
    e.fld  = fld;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic idle_all();
    for (int d = 1; d <= 4; d++) begin
      trig[d]  = 1'b0;
      check[d] = 1'b0;
    end
    mi1.mfi_valid = '0; mi1.mfi_order = '0; mi1.mfi_halt = '0;
    mi2.mfi_valid = '0; mi2.mfi_order = '0; mi2.mfi_halt = '0;
    mi3.mfi_valid = '0; mi3.mfi_order = '0; mi3.mfi_halt = '0;
    mi4.mfi_valid = '0; mi4.mfi_order = '0; mi4.mfi_halt = '0;
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 1; d <= 4; d++) inst[d] = '0;
    idle_all();
    tick();
    tick();
    for (int d = 1; d <= 4; d++) begin
      expect_now(d, F_ARMED, 0, "rst_armed");
      expect_now(d, F_DONE,  0, "rst_done");
      expect_now(d, F_WC,    0, "rst_wait_cnt");
      expect_now(d, F_FOUND, 0, "rst_found");
    end
    reset = 1'b0;

    // NRET=1, DEPTH=1: trig on order 5 (check in the same cycle is vacuous), then 6.
    inst[1] = 32'd5;
    trig[1] = 1'b1; check[1] = 1'b1;
    mi1.mfi_valid = 1'b1; mi1.mfi_order = 32'd5;
    tick();
    expect_now(1, F_ARMED, 1, "t1_armed");
    expect_now(1, F_DONE,  0, "t1_done_early");
    expect_now(1, F_WC,    1, "t1_wait_cnt");
    trig[1] = 1'b0; check[1] = 1'b0;
    mi1.mfi_order = 32'd6;
    tick();
    expect_now(1, F_FOUND, 1, "t1_found");
    expect_now(1, F_DONE,  0, "t1_done_lat1");
    mi1.mfi_valid = 1'b0;
    tick();
    expect_now(1, F_DONE, 1, "t1_done");
    tick();
    check[1] = 1'b1; trig[1] = 1'b1;
    mi1.mfi_valid = 1'b1; mi1.mfi_order = 32'd5;
    tick();
    expect_now(1, F_DONE,  1, "t1_done_hold");
    expect_now(1, F_WC,    1, "t1_wc_hold");
    idle_all();

    // NRET=2, DEPTH=3: 11 and 12 together, 13 two cycles later.
    inst[2] = 32'd10;
    trig[2] = 1'b1;
    mi2.mfi_valid = 2'b01; mi2.mfi_order = {32'd0, 32'd10};
    tick();
    expect_now(2, F_ARMED, 1, "t2_armed");
    expect_now(2, F_FOUND, 0, "t2_found0");
    trig[2] = 1'b0;
    mi2.mfi_valid = 2'b11; mi2.mfi_order = {32'd12, 32'd11};
    tick();
    expect_now(2, F_FOUND, 3'b011, "t2_found_011");
    expect_now(2, F_DONE,  0, "t2_done_a");
    mi2.mfi_valid = 2'b00;
    tick();
    expect_now(2, F_DONE, 0, "t2_done_b");
    mi2.mfi_valid = 2'b10; mi2.mfi_order = {32'd13, 32'd0};
    tick();
    expect_now(2, F_FOUND, 3'b111, "t2_found_111");
    expect_now(2, F_DONE,  0, "t2_done_c");
    mi2.mfi_valid = 2'b00;
    tick();
    expect_now(2, F_DONE, 1, "t2_done");
    check[2] = 1'b1;
    tick();
    idle_all();

    // Halt cut: DEPTH=4, inst+2 halts, inst+1 retires alongside.
    inst[3] = 32'd100;
    trig[3] = 1'b1;
    mi3.mfi_valid = 2'b01; mi3.mfi_order = {32'd0, 32'd100};
    tick();
    expect_now(3, F_WC, 1, "t3_wc1");
    trig[3] = 1'b0;
    mi3.mfi_valid = 2'b11; mi3.mfi_order = {32'd101, 32'd102}; mi3.mfi_halt = 2'b01;
    tick();
    expect_now(3, F_FOUND, 4'b0011, "t3_found");
    expect_now(3, F_DONE,  0, "t3_done_early");
    expect_now(3, F_WC,    2, "t3_wc2");
    mi3.mfi_valid = 2'b00; mi3.mfi_halt = 2'b00;
    tick();
    expect_now(3, F_DONE, 1, "t3_done_cut");
    expect_now(3, F_WC,   3, "t3_wc3");
    check[3] = 1'b1;
    tick();
    expect_now(3, F_WC, 3, "t3_wc_hold");
    idle_all();

    // Wrap: inst_order all-ones, targets 0x0 and 0x1.
    inst[4] = 32'hFFFF_FFFF;
    trig[4] = 1'b1;
    mi4.mfi_valid = 2'b11; mi4.mfi_order = {32'h0, 32'hFFFF_FFFF};
    tick();
    expect_now(4, F_FOUND, 2'b01, "t4_found_01");
    expect_now(4, F_WC,    1, "t4_wc1");
    trig[4] = 1'b0;
    mi4.mfi_valid = 2'b01; mi4.mfi_order = {32'h0, 32'h1};
    tick();
    expect_now(4, F_FOUND, 2'b11, "t4_found_11");
    expect_now(4, F_DONE,  0, "t4_done_early");
    mi4.mfi_valid = 2'b00;
    tick();
    expect_now(4, F_DONE, 1, "t4_done_wrap");
    expect_now(4, F_WC,   3, "t4_wc3");
    check[4] = 1'b1;
    tick();
    idle_all();

    // Reset while waiting with found=01, then a clean restart finishing on the deadline boundary.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inst[4] = 32'd50;
    trig[4] = 1'b1;
    mi4.mfi_valid = 2'b11; mi4.mfi_order = {32'd51, 32'd50};
    tick();
    expect_now(4, F_FOUND, 2'b01, "t5_found_01");
    expect_now(4, F_ARMED, 1, "t5_armed");
    reset = 1'b1;
    idle_all();
    tick();
    expect_now(4, F_ARMED, 0, "t5_rst_armed");
    expect_now(4, F_WC,    0, "t5_rst_wc");
    expect_now(4, F_FOUND, 0, "t5_rst_found");
    reset = 1'b0;
    trig[4] = 1'b1;
    mi4.mfi_valid = 2'b01; mi4.mfi_order = {32'd0, 32'd50};
    tick();
    expect_now(4, F_WC,    1, "t5_re_wc1");
    expect_now(4, F_FOUND, 0, "t5_re_found0");
    trig[4] = 1'b0; mi4.mfi_valid = 2'b00;
    tick();
    expect_now(4, F_WC, 2, "t5_re_wc2");
    mi4.mfi_valid = 2'b01; mi4.mfi_order = {32'd0, 32'd52};
    tick();
    expect_now(4, F_FOUND, 2'b10, "t5_found_10");
    mi4.mfi_order = {32'd0, 32'd51};
    tick();
    expect_now(4, F_FOUND, 2'b11, "t5_found_11");
    expect_now(4, F_WC,    4, "t5_wc4");
    expect_now(4, F_DONE,  0, "t5_done_early");
    mi4.mfi_valid = 2'b00;
    tick();
    expect_now(4, F_DONE, 1, "t5_done_at_deadline");
    expect_now(4, F_WC,   5, "t5_wc5");

    // Deadline: no successor ever retires in time.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inst[4] = 32'd70;
    trig[4] = 1'b1;
    mi4.mfi_valid = 2'b01; mi4.mfi_order = {32'd0, 32'd70};
    tick();
    trig[4] = 1'b0; mi4.mfi_valid = 2'b00;
    tick();
    tick();
    tick();
    expect_now(4, F_WC,    4, "t6_wc4");
    expect_now(4, F_ARMED, 1, "t6_armed");
    tick();
    expect_now(4, F_WC,   5, "t6_wc5");
    expect_now(4, F_DONE, 0, "t6_expired_done");
    mi4.mfi_valid = 2'b01; mi4.mfi_order = {32'd0, 32'd71};
    tick();
    mi4.mfi_order = {32'd0, 32'd72};
    tick();
    mi4.mfi_valid = 2'b00;
    tick();
    tick();
    expect_now(4, F_FOUND, 2'b11, "t6_found_late");
    expect_now(4, F_DONE,  0, "t6_terminal");
    expect_now(4, F_WC,    5, "t6_wc_sat");

    tick();
    tick();
    while (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never compared (stamped cycle %0d)", sbq[0].name, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
